multi_chan_fifo: RTL and testbench
==================================

# multi_chan_fifo

Parametrised multi-channel synchronous FIFO for the VGG16 datapath. It buffers CHANNELS lanes of DATA_WIDTH bits as one word, for example RGB triplets or parallel feature-map lanes between the line buffers and the convolution engine. Compared with the earlier fixed 3-lane FIFO, it adds:
- any depth, not only powers of two;
- an occupancy count;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags;
- a compile-time choice between registered-read and first-word-fall-through (FWFT) read.

## Interface
Parameters:
- DATA_WIDTH, 32, bits per channel
- CHANNELS, 3, lanes per word; word width W = DATA_WIDTH*CHANNELS
- DEPTH, 4, number of entries; must be ≥2; need not be a power of two
- AFULL_TH, DEPTH-1, almost_full asserts when count ≥ AFULL_TH
- AEMPTY_TH, 1, almost_empty asserts when count ≤ AEMPTY_TH

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write request
- wr_data  in  W  write word; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- rd_en  in  1  read (pop) request
- rd_data  out  W  read word
- rd_valid  out  1  rd_data holds a popped word; meaning depends on mode, see Configuration
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_TH
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
Write and read acceptance:
- A write is accepted when wr_en && !full. An accepted write stores wr_data at wr_ptr, and wr_ptr advances.
- A read is accepted when rd_en && !empty. An accepted read advances rd_ptr.

Pointers and count:
- wr_ptr and rd_ptr range over 0..DEPTH-1. Each wraps explicitly from DEPTH-1 to 0. There is no extra wrap bit.
- count is a register:
  - +1 on an accepted write only;
  - -1 on an accepted read only;
  - unchanged when both or neither are accepted.
- full, empty, almost_full and almost_empty are decoded combinationally from count.

Boundary conditions:
- Write while full: the word is dropped, overflow is set, and the pointers are unchanged. A write is not accepted when full, even if a read is accepted in the same cycle.
- Read while empty: ignored, and underflow is set. A write in the same cycle is still accepted. There is no bypass, so that word becomes readable at the earliest in the next cycle.
- Simultaneous accepted read and write: both pointers advance and count is unchanged. This includes count == 1 and count == DEPTH-1.
- overflow and underflow clear only on rst.
- Memory contents are not reset.

## Timing
Reset values:
- count = 0, empty = 1, full = 0, almost_empty = 1.
- almost_full = (AFULL_TH == 0).
- overflow = 0, underflow = 0, rd_valid = 0, rd_data = 0.
- Both pointers = 0.

Latency and updates:
- All flags and count update on the clock edge that accepts the operation.
- Write-to-readable latency is 1 cycle: empty falls the cycle after the first accepted write.
- rst asserted mid-operation immediately discards all contents and returns every output to its reset value. Operation resumes on the first clock edge after rst deasserts.

## Configuration
- FIFO_FWFT_EN undefined (registered read):
  - rd_data is registered and updates on the edge that accepts a read, i.e. 1-cycle read latency.
  - rd_valid pulses high for exactly one cycle after each accepted read.
  - rd_data holds its last value until the next accepted read.
- FIFO_FWFT_EN defined (first-word fall-through):
  - rd_data always shows the head entry, with 0 latency.
  - rd_valid = !empty.
  - rd_en acknowledges and pops the head.
  - rd_data is 0 while empty.

## Structure
- Package multi_chan_fifo_pkg holds:
  - the ptr-width and count-width helper functions, $clog2(DEPTH) with a minimum of 1 and $clog2(DEPTH+1);
  - the default parameter constants.
- Sub-module fifo_ram: simple dual-port memory with DEPTH×W entries.
  - Synchronous write.
  - Asynchronous read when FIFO_FWFT_EN is defined; registered read otherwise.
- The top level contains the pointers, count, flags and error logic.

## Test plan
Default parameters (DEPTH=4, CHANNELS=3, DATA_WIDTH=32) unless stated.

1. Reset, then write 0x1/0x2/0x3/0x4 on 4 consecutive cycles:
   - count goes 1, 2, 3, 4;
   - full = 1 after the 4th write;
   - almost_full = 1 from count 3.
   Then 4 reads return 1, 2, 3, 4 in order, and empty = 1 after the last.
2. With the FIFO full, assert wr_en with 0x5:
   - overflow = 1 and count stays 4;
   - subsequent reads return 1–4 and never 0x5.
3. From reset, assert rd_en while empty:
   - underflow = 1 and rd_valid stays 0 in registered mode;
   - with wr_en in the same cycle, count = 1 the next cycle.
4. Set DEPTH=5 and run 12 writes interleaved with reads so the pointers wrap twice:
   - data order is preserved;
   - full occurs at count 5.
5. At count 2, assert simultaneous rd_en and wr_en for 10 cycles:
   - count stays 2 and the outputs are in write order.
   Run in both FIFO_FWFT_EN modes and check rd_data latency: 0 cycles in FWFT, 1 cycle in registered mode.
6. Assert rst mid-stream with count 3 and overflow = 1:
   - next cycle: count = 0, empty = 1, overflow = 0;
   - a following write then read returns the new word only.

Source files
------------

// File: rtl/multi_chan_fifo_pkg.sv
// multi_chan_fifo_pkg: shared constants and width helpers for the multi-channel FIFO.
//   Default parameter values for multi_chan_fifo and fifo_ram.
//   ptr_width(depth)   : pointer width, $clog2(depth) with a floor of 1.
//   count_width(depth) : occupancy width, $clog2(depth+1).
package multi_chan_fifo_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefChannels  = 3;
  localparam int unsigned DefDepth     = 4;
  localparam int unsigned DefAemptyTh  = 1;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage of DEPTH words of WIDTH bits.
// Synchronous write. Read is asynchronous when FIFO_FWFT_EN is defined, otherwise
// registered (rdata loads mem[raddr] on a clock edge with re high; cleared by rst).
// Memory contents are never reset.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr     : read enable / address
//   rdata        : read word
module fifo_ram
  import multi_chan_fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = DefDataWidth * DefChannels,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef FIFO_FWFT_EN
  assign rdata = mem[raddr];

  // Read enable and reset have no role with an asynchronous read path.
  logic unused_ctrl;
  assign unused_ctrl = rst ^ re;
`else
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: rtl/multi_chan_fifo.sv
// multi_chan_fifo: CHANNELS x DATA_WIDTH synchronous FIFO of arbitrary DEPTH (>= 2).
// Build option: define FIFO_FWFT_EN for first-word fall-through read; otherwise the
// read is registered (1-cycle latency, rd_valid pulses once per accepted read).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   wr_en, wr_data  : write request / word (channel c at [c*DATA_WIDTH +: DATA_WIDTH])
//   rd_en           : read (pop) request
//   rd_data, rd_valid : read word and its qualifier
//   full, empty, almost_full, almost_empty : decoded from count
//   count           : occupancy
//   overflow, underflow : sticky error flags, cleared only by rst
module multi_chan_fifo
  import multi_chan_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned CHANNELS   = DefChannels,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned AFULL_TH   = DEPTH - 1,
  parameter int unsigned AEMPTY_TH  = DefAemptyTh
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [DATA_WIDTH*CHANNELS-1:0]   wr_data,
  input  logic                             rd_en,
  output logic [DATA_WIDTH*CHANNELS-1:0]   rd_data,
  output logic                             rd_valid,
  output logic                             full,
  output logic                             empty,
  output logic                             almost_full,
  output logic                             almost_empty,
  output logic [count_width(DEPTH)-1:0]    count,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int unsigned W    = DATA_WIDTH * CHANNELS;
  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = count_width(DEPTH);

  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            wr_acc, rd_acc;
  logic [W-1:0]    ram_rdata;

  assign full         = (count_q == CntFull);
  assign empty        = (count_q == '0);
  assign almost_full  = (32'(count_q) >= AFULL_TH);
  assign almost_empty = (32'(count_q) <= AEMPTY_TH);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO refuses writes even when a read frees a slot in the same cycle.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (wr_en & full);
    underflow_d = underflow_q | (rd_en & empty);

    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .WIDTH  (W),
    .DEPTH  (DEPTH),
    .ADDR_W (PtrW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

`ifdef FIFO_FWFT_EN
  // Head entry is visible combinationally; mask stale memory while empty.
  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : ram_rdata;
`else
  logic rd_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = ram_rdata;
`endif

endmodule

// File: tb/tb_multi_chan_fifo.sv
// tb_multi_chan_fifo: drives two FIFOs (DEPTH 4 and DEPTH 5) with the same stimulus and
// checks every output of each against a queue-based reference model on every cycle.
// Directed sequences plus literal expectations on the DEPTH 4 instance, then random traffic.
// Works in both read modes (FIFO_FWFT_EN defined or not).
module tb_multi_chan_fifo;

  localparam int unsigned W = 96;

  logic         clk     = 1'b0;
  logic         rst     = 1'b1;
  logic         wr_en   = 1'b0;
  logic         rd_en   = 1'b0;
  logic [W-1:0] wr_data = '0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned D  = (g == 0) ? 4 : 5;
    localparam int unsigned CW = $clog2(D + 1);

    logic [W-1:0]  rd_data;
    logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [CW-1:0] count;

    multi_chan_fifo #(
      .DATA_WIDTH (32),
      .CHANNELS   (3),
      .DEPTH      (D)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
    );

    // Reference model: contents as a queue, sticky errors, last popped word.
    logic [W-1:0] q [$];
    logic         m_ovf  = 1'b0;
    logic         m_udf  = 1'b0;
    logic         m_rv   = 1'b0;
    logic [W-1:0] m_last = '0;

    initial forever begin
      logic         s_wr, s_rd, s_rst, wacc, racc, exp_rv;
      logic [W-1:0] s_data, exp_rd;
      int unsigned  n;
      @(posedge clk);
      s_wr = wr_en; s_rd = rd_en; s_rst = rst; s_data = wr_data;
      #1;
      if (s_rst) begin
        q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0; m_last = '0;
      end else begin
        n = q.size();
        wacc = s_wr && (n < D);
        racc = s_rd && (n > 0);
        if (s_wr && n == D) m_ovf = 1'b1;
        if (s_rd && n == 0) m_udf = 1'b1;
        m_rv = racc;
        if (racc) m_last = q.pop_front();
        if (wacc) q.push_back(s_data);
      end
      n = q.size();
`ifdef FIFO_FWFT_EN
      exp_rv = (n != 0);
      exp_rd = (n != 0) ? q[0] : '0;
`else
      exp_rv = m_rv;
      exp_rd = m_last;
`endif
      chk($sformatf("d%0d count", D),        W'(count),        W'(n));
      chk($sformatf("d%0d full", D),         W'(full),         W'(n == D));
      chk($sformatf("d%0d empty", D),        W'(empty),        W'(n == 0));
      chk($sformatf("d%0d almost_full", D),  W'(almost_full),  W'(n >= D - 1));
      chk($sformatf("d%0d almost_empty", D), W'(almost_empty), W'(n <= 1));
      chk($sformatf("d%0d overflow", D),     W'(overflow),     W'(m_ovf));
      chk($sformatf("d%0d underflow", D),    W'(underflow),    W'(m_udf));
      chk($sformatf("d%0d rd_valid", D),     W'(rd_valid),     W'(exp_rv));
      chk($sformatf("d%0d rd_data", D),      rd_data,          exp_rd);
    end
  end

  // Drive one cycle of inputs at a falling edge and advance to the next falling edge.
  task automatic cyc(input logic w, input logic r, input logic [W-1:0] d);
    wr_en = w; rd_en = r; wr_data = d;
    @(negedge clk);
  endtask

  // Pop one word from the DEPTH 4 instance and check it against a literal value.
  task automatic pop_chk(input string name, input logic [W-1:0] exp);
`ifdef FIFO_FWFT_EN
    chk(name, g_inst[0].rd_data, exp);
    cyc(1'b0, 1'b1, '0);
`else
    cyc(1'b0, 1'b1, '0);
    chk(name, g_inst[0].rd_data, exp);
`endif
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset count",        W'(g_inst[0].count),        W'(0));
    chk("reset empty",        W'(g_inst[0].empty),        W'(1));
    chk("reset full",         W'(g_inst[0].full),         W'(0));
    chk("reset almost_empty", W'(g_inst[0].almost_empty), W'(1));
    chk("reset almost_full",  W'(g_inst[0].almost_full),  W'(0));
    chk("reset rd_valid",     W'(g_inst[0].rd_valid),     W'(0));
    chk("reset rd_data",      g_inst[0].rd_data,          W'(0));
    rst = 1'b0;

    // Fill 1..4, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 1'b0, W'(i));
      chk($sformatf("fill count %0d", i), W'(g_inst[0].count), W'(i));
      chk($sformatf("fill almost_full %0d", i), W'(g_inst[0].almost_full), W'(i >= 3));
    end
    chk("fill full", W'(g_inst[0].full), W'(1));
    for (int i = 1; i <= 4; i++) pop_chk($sformatf("drain data %0d", i), W'(i));
    chk("drain empty", W'(g_inst[0].empty), W'(1));

    // Overflow: refill, then write while full.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, W'(i));
    cyc(1'b1, 1'b0, W'(5));
    chk("ovf flag",  W'(g_inst[0].overflow), W'(1));
    chk("ovf count", W'(g_inst[0].count),    W'(4));
    chk("d5 count at 5th write", W'(g_inst[1].count), W'(5));
    chk("d5 full at 5",          W'(g_inst[1].full),  W'(1));
    cyc(1'b1, 1'b0, W'(6));
    for (int i = 1; i <= 4; i++) pop_chk($sformatf("ovf drain %0d", i), W'(i));
    cyc(1'b0, 1'b1, '0);
    cyc(1'b0, 1'b0, '0);

    // Underflow from reset, then read+write while empty.
    rst = 1'b1;
    cyc(1'b0, 1'b0, '0);
    rst = 1'b0;
    chk("post-reset overflow", W'(g_inst[0].overflow), W'(0));
    cyc(1'b0, 1'b1, '0);
    chk("udf flag",     W'(g_inst[0].underflow), W'(1));
    chk("udf rd_valid", W'(g_inst[0].rd_valid),  W'(0));
    cyc(1'b1, 1'b1, W'(32'h77));
    chk("udf+wr count", W'(g_inst[0].count), W'(1));

    // Steady state at count 2 with simultaneous read and write.
    cyc(1'b1, 1'b0, W'(32'h78));
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, W'(32'h100 + i));
      chk($sformatf("rw count %0d", i), W'(g_inst[0].count), W'(2));
    end

    // Reset mid-stream with count 3 and overflow set.
    cyc(1'b1, 1'b0, W'(32'h200));
    cyc(1'b1, 1'b0, W'(32'h201));
    cyc(1'b1, 1'b0, W'(32'h202));
    cyc(1'b0, 1'b1, '0);
    chk("pre-rst count",    W'(g_inst[0].count),    W'(3));
    chk("pre-rst overflow", W'(g_inst[0].overflow), W'(1));
    rst = 1'b1;
    cyc(1'b0, 1'b0, '0);
    chk("rst count",    W'(g_inst[0].count),    W'(0));
    chk("rst empty",    W'(g_inst[0].empty),    W'(1));
    chk("rst overflow", W'(g_inst[0].overflow), W'(0));
    rst = 1'b0;
    cyc(1'b1, 1'b0, W'(32'hABC));
    pop_chk("post-rst data", W'(32'hABC));
    chk("post-rst empty", W'(g_inst[0].empty), W'(1));

    // Random traffic: write-heavy, read-heavy, then balanced; pointers wrap many times.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 400; i++) begin
        int unsigned pw, pr;
        pw = (ph == 0) ? 75 : (ph == 1) ? 30 : 55;
        pr = (ph == 0) ? 35 : (ph == 1) ? 75 : 55;
        cyc($urandom_range(99) < pw, $urandom_range(99) < pr,
            {$urandom(), $urandom(), $urandom()});
      end
    end
    cyc(1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
